// File: rtl/uart_rx_framer.sv
// UART 8N1 receiver: oversampled bit timing with 3-sample majority vote,
// start-glitch rejection, framing-error and overrun pulses, and a single
// valid/ready holding register on the output.
module uart_rx_framer #(
  parameter int CLK_HZ     = 40000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE)
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TC_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [TC_W-1:0]  TC_LAST  = TC_W'(OVERSAMPLE - 1);
  // Tick n of a bit is the tick that brings tick_cnt to n; the three
  // samples straddle the bit centre at OVERSAMPLE/2.
  localparam logic [TC_W-1:0]  TC_S0    = TC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TC_W-1:0]  TC_S1    = TC_W'(OVERSAMPLE / 2);
  localparam logic [TC_W-1:0]  TC_S2    = TC_W'(OVERSAMPLE / 2 + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sync1;
  logic             rx_s;
  logic             rx_prev;
  logic [DIV_W-1:0] div_cnt;
  logic [TC_W-1:0]  tick_cnt;
  logic [TC_W-1:0]  tick_nxt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             s0;
  logic             s1;
  logic             fall;
  logic             tick;
  logic             decide;
  logic             maj;
  logic             good;
  logic             bad;

  assign fall     = rx_prev & ~rx_s;
  assign tick     = (state != IDLE) && (div_cnt == DIV_LAST);
  assign tick_nxt = (tick_cnt == TC_LAST) ? '0 : tick_cnt + 1'b1;
  assign decide   = tick && (tick_nxt == TC_S2);
  assign maj      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign good     = (state == STOP) && decide && maj;
  assign bad      = (state == STOP) && decide && !maj;
  assign busy_o   = (state != IDLE);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync1   <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      sync1   <= rx_i;
      rx_s    <= sync1;
      rx_prev <= rx_s;
    end
  end

  // Tick divider and per-bit tick counter; both parked at zero while idle so
  // a frame always starts timing from the detected start edge.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else if (state == IDLE) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) tick_cnt <= tick_nxt;
    end
  end

  // Capture the first two majority samples; the third is rx_s at decision.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
    end else begin
      if (tick && (tick_nxt == TC_S0)) s0 <= rx_s;
      if (tick && (tick_nxt == TC_S1)) s1 <= rx_s;
    end
  end

  // Data bits shift in LSB first; bit_idx saturates at 7.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state != DATA) begin
      bit_idx <= '0;
    end else if (decide) begin
      shreg <= {maj, shreg[7:1]};
      if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Frame sequencing; STOP is left at mid-stop-bit so back-to-back frames work.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (decide) state_nxt = maj ? IDLE : DATA;
      DATA:  if (decide && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:  if (decide) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output holding register with overrun and framing-error pulses.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= bad;
      overrun_o   <= good && valid_o && !ready_i;
      if (good && (!valid_o || ready_i)) begin
        data_o  <= shreg;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: bit-banged frames, scoreboard of
// expected bytes popped on each valid/ready handshake.
`timescale 1ns/1ps
module tb_uart_rx_framer;

  localparam int BT = 352;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       ready;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  logic [7:0] sb[$];
  int pass_cnt = 0;
  int fail_cnt = 0;
  int chk_cnt  = 0;
  int cyc = 0;
  int vhigh_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cnt = 0;
  int rise_cyc = 0;
  int start_cyc = 0;
  logic valid_q = 1'b0;
  int v0, f0, o0, b0;

  uart_rx_framer dut (
    .clk_i(clk),
    .reset_i(rst_n),
    .rx_i(rx),
    .data_o(data_o),
    .valid_o(valid_o),
    .ready_i(ready),
    .frame_err_o(frame_err_o),
    .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    chk_cnt++;
    assert (obs >= lo && obs <= hi) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Monitor: pulse/level counters and scoreboard pop on handshake.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (valid_o) vhigh_cnt++;
    if (valid_o && !valid_q) rise_cyc = cyc;
    valid_q = valid_o;
    if (frame_err_o) fe_cnt++;
    if (overrun_o) ov_cnt++;
    if (busy_o) busy_cnt++;
    if (valid_o && ready) begin
      check("sb_has_entry", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        check("rx_byte", data_o, exp_b);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic v, input int n);
    rx = v;
    step(n);
  endtask

  // gbit selects a data bit that gets a one-tick low pulse at its centre.
  task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_v, input int gbit);
    start_cyc = cyc;
    send_bit(1'b0, bt);
    for (int i = 0; i < 8; i++) begin
      if (i == gbit) begin
        send_bit(b[i], bt / 2 - 11);
        send_bit(1'b0, 22);
        send_bit(b[i], bt - bt / 2 - 11);
      end else begin
        send_bit(b[i], bt);
      end
    end
    send_bit(stop_v, bt);
    rx = 1'b1;
  endtask

  initial begin
    rx = 1'b1;
    ready = 1'b0;
    rst_n = 1'b0;
    step(3);
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    rst_n = 1'b1;
    step(20);

    // 0x55 with consumer always ready
    ready = 1'b1;
    v0 = vhigh_cnt; f0 = fe_cnt; o0 = ov_cnt;
    sb.push_back(8'h55);
    send_frame(8'h55, BT, 1'b1, -1);
    step(50);
    check_range("t1_latency", rise_cyc - start_cyc, 3316, 3376);
    check("t1_sb_drained", sb.size(), 0);
    check("t1_valid_cycles", vhigh_cnt - v0, 1);
    check("t1_ferr", fe_cnt - f0, 0);
    check("t1_ovr", ov_cnt - o0, 0);

    // 0xA3 held until consumer accepts
    ready = 1'b0;
    sb.push_back(8'hA3);
    send_frame(8'hA3, BT, 1'b1, -1);
    step(100);
    check("t2_valid", valid_o, 1);
    check("t2_data", data_o, 8'hA3);
    check("t2_sb_pending", sb.size(), 1);
    step(1000);
    check("t2_valid_hold", valid_o, 1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    step(2);
    check("t2_valid_drop", valid_o, 0);
    check("t2_sb_drained", sb.size(), 0);

    // back-to-back 0x11, 0x22 with consumer stalled: second byte overruns
    o0 = ov_cnt;
    sb.push_back(8'h11);
    send_frame(8'h11, BT, 1'b1, -1);
    send_frame(8'h22, BT, 1'b1, -1);
    step(100);
    check("t3_ovr_once", ov_cnt - o0, 1);
    check("t3_data_kept", data_o, 8'h11);
    check("t3_valid", valid_o, 1);
    ready = 1'b1;
    step(1);
    step(2);
    check("t3_sb_drained", sb.size(), 0);
    check("t3_valid_drop", valid_o, 0);

    // framing error, then a good frame
    v0 = vhigh_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'h3C, BT, 1'b0, -1);
    step(400);
    check("t4_ferr_once", fe_cnt - f0, 1);
    check("t4_no_valid", vhigh_cnt - v0, 0);
    check("t4_no_ovr", ov_cnt - o0, 0);
    sb.push_back(8'h7E);
    send_frame(8'h7E, BT, 1'b1, -1);
    step(50);
    check("t4_sb_drained", sb.size(), 0);
    check("t4_ferr_total", fe_cnt - f0, 1);
    check("t4_valid_cycles", vhigh_cnt - v0, 1);

    // start glitch of 100 clocks
    v0 = vhigh_cnt; f0 = fe_cnt; b0 = busy_cnt;
    rx = 1'b0;
    step(100);
    rx = 1'b1;
    step(400);
    check_range("t5_busy_cycles", busy_cnt - b0, 190, 210);
    check("t5_no_valid", vhigh_cnt - v0, 0);
    check("t5_no_ferr", fe_cnt - f0, 0);
    check("t5_busy_low", busy_o, 0);

    // 0xC6 at -3% and +3% rate, one-tick low pulse mid third data bit
    v0 = vhigh_cnt; f0 = fe_cnt;
    sb.push_back(8'hC6);
    send_frame(8'hC6, 363, 1'b1, 2);
    step(100);
    check("t6_slow_sb", sb.size(), 0);
    sb.push_back(8'hC6);
    send_frame(8'hC6, 341, 1'b1, 2);
    step(100);
    check("t6_fast_sb", sb.size(), 0);
    check("t6_valid_cycles", vhigh_cnt - v0, 2);
    check("t6_no_ferr", fe_cnt - f0, 0);

    // reset in the middle of the data bits
    ready = 1'b0;
    f0 = fe_cnt; o0 = ov_cnt;
    send_bit(1'b0, BT);
    send_bit(1'b1, BT);
    send_bit(1'b0, BT);
    send_bit(1'b0, BT / 2);
    check("t7_busy_pre", busy_o, 1);
    check("t7_data_pre", data_o, 8'hC6);
    #1;
    rst_n = 1'b0;
    #1;
    check("t7_busy_rst", busy_o, 0);
    check("t7_data_rst", data_o, 0);
    check("t7_valid_rst", valid_o, 0);
    rx = 1'b1;
    step(5);
    rst_n = 1'b1;
    step(20);
    ready = 1'b1;
    sb.push_back(8'h81);
    send_frame(8'h81, BT, 1'b1, -1);
    step(50);
    check("t7_sb_drained", sb.size(), 0);
    check("t7_no_ferr", fe_cnt - f0, 0);
    check("t7_no_ovr", ov_cnt - o0, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
